// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Bundles the three streams around the ALU command sequencer.
//   Command stream : cmd_valid/cmd_ready with cmd_a, cmd_b, cmd_sv, cmd_prefix, cmd_op.
//   ALU handshake  : alu_start with alu_a/alu_b/alu_sv/alu_prefix/alu_op out,
//                    alu_done with alu_result/alu_err/alu_gp back.
//   Response stream: rsp_valid/rsp_ready with rsp_result, rsp_err, rsp_gp, rsp_op, rsp_timeout.
//   Status         : busy, cmd_count (FIFO occupancy).
//   master = the sequencer itself, slave = the host/ALU side around it.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int RES_W  = 64,
  parameter int OP_W   = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_sv;
  logic              cmd_prefix;
  logic [OP_W-1:0]   cmd_op;

  logic              alu_start;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_sv;
  logic              alu_prefix;
  logic [OP_W-1:0]   alu_op;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;
  logic [7:0]        alu_err;
  logic              alu_gp;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [7:0]        rsp_err;
  logic              rsp_gp;
  logic [OP_W-1:0]   rsp_op;
  logic              rsp_timeout;

  logic              busy;
  logic [CNT_W-1:0]  cmd_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_sv, cmd_prefix, cmd_op,
    output cmd_ready,
    output alu_start, alu_a, alu_b, alu_sv, alu_prefix, alu_op,
    input  alu_done, alu_result, alu_err, alu_gp,
    output rsp_valid, rsp_result, rsp_err, rsp_gp, rsp_op, rsp_timeout,
    input  rsp_ready,
    output busy, cmd_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_sv, cmd_prefix, cmd_op,
    input  cmd_ready,
    input  alu_start, alu_a, alu_b, alu_sv, alu_prefix, alu_op,
    output alu_done, alu_result, alu_err, alu_gp,
    input  rsp_valid, rsp_result, rsp_err, rsp_gp, rsp_op, rsp_timeout,
    output rsp_ready,
    input  busy, cmd_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Buffers ALU commands in a DEPTH-entry FIFO and runs them through the tiny-ALU
//   start/done handshake one at a time. Each command yields exactly one response:
//   the ALU result, a timeout marker (err 8'hFF) if alu_done never comes, or an
//   illegal-opcode marker (err 8'hFE) for opcodes above MAX_OP, which never reach the ALU.
// Ports
//   clk   : clock, all logic on posedge
//   reset : asynchronous, active-high
//   bus   : alu_cmd_sequencer_if.master (command, ALU and response streams, status)
module alu_cmd_sequencer #(
  parameter int DATA_W  = 32,
  parameter int RES_W   = 64,
  parameter int OP_W    = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int MAX_OP  = 10
) (
  input logic                 clk,
  input logic                 reset,
  alu_cmd_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TM_W  = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 2 * DATA_W + OP_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_W'(MAX_OP);
  endfunction

  state_t            r_state;
  logic [TM_W-1:0]   r_timer;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_alu_start;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_alu_sv;
  logic              r_alu_prefix;
  logic [OP_W-1:0]   r_alu_op;

  logic              r_rsp_valid;
  logic [RES_W-1:0]  r_rsp_result;
  logic [7:0]        r_rsp_err;
  logic              r_rsp_gp;
  logic [OP_W-1:0]   r_rsp_op;
  logic              r_rsp_timeout;

  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic [OP_W-1:0]   w_head_op;
  logic              w_head_sv;
  logic              w_head_prefix;

  assign bus.cmd_ready = (r_count < CNT_W'(DEPTH));
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  // The head is only consumed from IDLE, so one pop starts at most one command.
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);

  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_a      = w_head[DATA_W-1:0];
  assign w_head_b      = w_head[2*DATA_W-1:DATA_W];
  assign w_head_op     = w_head[2*DATA_W +: OP_W];
  assign w_head_sv     = w_head[2*DATA_W+OP_W];
  assign w_head_prefix = w_head[ENT_W-1];

  // FIFO storage carries no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.cmd_prefix, bus.cmd_sv, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_alu_start   <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_sv      <= 1'b0;
      r_alu_prefix  <= 1'b0;
      r_alu_op      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_err     <= '0;
      r_rsp_gp      <= 1'b0;
      r_rsp_op      <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (op_legal(w_head_op)) begin
              r_alu_a      <= w_head_a;
              r_alu_b      <= w_head_b;
              r_alu_sv     <= w_head_sv;
              r_alu_prefix <= w_head_prefix;
              r_alu_op     <= w_head_op;
              r_alu_start  <= 1'b1;
              r_timer      <= '0;
              r_state      <= S_WAIT;
            end else begin
              // Illegal opcode: answered locally, the ALU never sees it.
              r_rsp_result  <= '0;
              r_rsp_err     <= 8'hFE;
              r_rsp_gp      <= 1'b0;
              r_rsp_op      <= w_head_op;
              r_rsp_timeout <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_state       <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // alu_done is checked first so it wins over a timeout in the same cycle.
          if (bus.alu_done) begin
            r_rsp_result  <= bus.alu_result;
            r_rsp_err     <= bus.alu_err;
            r_rsp_gp      <= bus.alu_gp;
            r_rsp_op      <= r_alu_op;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_alu_start   <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_timer == TM_W'(TIMEOUT - 1)) begin
            r_rsp_result  <= '0;
            r_rsp_err     <= 8'hFF;
            r_rsp_gp      <= 1'b0;
            r_rsp_op      <= r_alu_op;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_alu_start   <= 1'b0;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_GAP;
          end
        end
        // GAP guarantees at least one low cycle on alu_start between commands.
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_start   = r_alu_start;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_sv      = r_alu_sv;
  assign bus.alu_prefix  = r_alu_prefix;
  assign bus.alu_op      = r_alu_op;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_gp      = r_rsp_gp;
  assign bus.rsp_op      = r_rsp_op;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.busy        = (r_state != S_IDLE) || (r_count != '0);
  assign bus.cmd_count   = r_count;
endmodule
